// File: rtl/vmem_fill_pkg.sv
// Shared constants, register map and FSM encoding for the vmem rectangle-fill engine.
package vmem_fill_pkg;

    localparam logic [1:0] REG_XY    = 2'd0;
    localparam logic [1:0] REG_WH    = 2'd1;
    localparam logic [1:0] REG_COLOR = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    // CTRL write bits
    localparam int unsigned CTRL_START_BIT   = 0;
    localparam int unsigned CTRL_PATTERN_BIT = 1;

    localparam int unsigned LCD_W_DEFAULT = 240;
    localparam int unsigned LCD_H_DEFAULT = 240;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } fill_state_e;

    function automatic logic [2:0] pick_colour(input logic       pattern,
                                               input logic       parity,
                                               input logic [2:0] c0,
                                               input logic [2:0] c1);
        return (pattern && parity) ? c1 : c0;
    endfunction

endpackage

// File: rtl/vmem_fill_walker.sv
// Column/row walker for the fill engine: stallable counters, last-pixel flag and
// screen clipping of the current pixel.
module vmem_fill_walker
    import vmem_fill_pkg::*;
#(
    parameter int unsigned LCD_W = LCD_W_DEFAULT,
    parameter int unsigned LCD_H = LCD_H_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        advance_i,
    input  logic [7:0]  x0_i,
    input  logic [7:0]  y0_i,
    input  logic [7:0]  w_i,
    input  logic [7:0]  h_i,
    output logic        last_o,
    output logic        inside_o,
    output logic        parity_o,
    output logic [15:0] addr_o
);

    logic [7:0] col_q, col_d;
    logic [7:0] row_q, row_d;
    logic       col_end;
    logic [8:0] x_sum;
    logic [8:0] y_sum;

    assign col_end = (col_q == w_i - 8'd1);
    assign last_o  = col_end && (row_q == h_i - 8'd1);

    // 9-bit sums so a coordinate past 255 is clipped rather than wrapping on-screen
    assign x_sum    = {1'b0, x0_i} + {1'b0, col_q};
    assign y_sum    = {1'b0, y0_i} + {1'b0, row_q};
    assign inside_o = (x_sum < 9'(LCD_W)) && (y_sum < 9'(LCD_H));
    assign addr_o   = {y_sum[7:0], x_sum[7:0]};
    assign parity_o = col_q[0] ^ row_q[0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = 8'd0;
            row_d = 8'd0;
        end else if (advance_i) begin
            if (col_end) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= 8'd0;
            row_q <= 8'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/vmem_fill.sv
// Memory-mapped rectangle-fill engine and vmem write-port mux (CPU stores win).
// Optional checkerboard colouring is enabled by defining VMEM_FILL_PATTERN_EN.
module vmem_fill
    import vmem_fill_pkg::*;
#(
    parameter int unsigned LCD_W = LCD_W_DEFAULT,
    parameter int unsigned LCD_H = LCD_H_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_we_i,
    input  logic [1:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic [31:0] cfg_rdata_o,
    input  logic        cpu_vmem_we_i,
    input  logic [15:0] cpu_vmem_addr_i,
    input  logic [2:0]  cpu_vmem_wdata_i,
    output logic        vmem_we_o,
    output logic [15:0] vmem_addr_o,
    output logic [2:0]  vmem_wdata_o,
    output logic        busy_o,
    output logic        done_o
);

    fill_state_e state_q, state_d;

    // Programmed registers
    logic [7:0]  x0_q, y0_q, w_q, h_q;
    logic [2:0]  c0_q, c1_q;
    // Working copies latched at start so reprogramming cannot disturb a fill
    logic [7:0]  wx0_q, wy0_q, ww_q, wh_q;
    logic [2:0]  wc0_q;
    logic        done_sticky_q;
    logic [31:0] rdata_q, rdata_d;

    logic        start_req;
    logic        start_fill;
    logic        engine_cycle;
    logic        walk_last;
    logic        walk_inside;
    logic        walk_parity;
    logic [15:0] walk_addr;
    logic [2:0]  pixel_colour;
    logic        pattern_rd;
    logic        unused_wdata;

    assign unused_wdata = ^cfg_wdata_i[31:16];
    assign start_req    = cfg_we_i && (cfg_addr_i == REG_CTRL) && cfg_wdata_i[CTRL_START_BIT];

`ifdef VMEM_FILL_PATTERN_EN
    logic [2:0] wc1_q;
    logic       wpat_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wc1_q  <= 3'd0;
            wpat_q <= 1'b0;
        end else if (start_fill) begin
            wc1_q  <= c1_q;
            wpat_q <= cfg_wdata_i[CTRL_PATTERN_BIT];
        end
    end

    assign pixel_colour = pick_colour(wpat_q, walk_parity, wc0_q, wc1_q);
    assign pattern_rd   = wpat_q;
`else
    logic unused_parity;

    assign unused_parity = walk_parity;
    assign pixel_colour  = wc0_q;
    assign pattern_rd    = 1'b0;
`endif

    vmem_fill_walker #(
        .LCD_W (LCD_W),
        .LCD_H (LCD_H)
    ) u_walker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (start_fill),
        .advance_i (engine_cycle),
        .x0_i      (wx0_q),
        .y0_i      (wy0_q),
        .w_i       (ww_q),
        .h_i       (wh_q),
        .last_o    (walk_last),
        .inside_o  (walk_inside),
        .parity_o  (walk_parity),
        .addr_o    (walk_addr)
    );

    always_comb begin
        state_d      = state_q;
        start_fill   = 1'b0;
        engine_cycle = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    start_fill = 1'b1;
                    state_d    = ((w_q == 8'd0) || (h_q == 8'd0)) ? StDone : StFill;
                end
            end
            StFill: begin
                busy_o       = 1'b1;
                engine_cycle = !cpu_vmem_we_i;
                if (engine_cycle && walk_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q <= 8'd0;
            y0_q <= 8'd0;
            w_q  <= 8'd0;
            h_q  <= 8'd0;
            c0_q <= 3'd0;
            c1_q <= 3'd0;
        end else if (cfg_we_i && (state_q != StFill)) begin
            case (cfg_addr_i)
                REG_XY: begin
                    x0_q <= cfg_wdata_i[7:0];
                    y0_q <= cfg_wdata_i[15:8];
                end
                REG_WH: begin
                    w_q <= cfg_wdata_i[7:0];
                    h_q <= cfg_wdata_i[15:8];
                end
                REG_COLOR: begin
                    c0_q <= cfg_wdata_i[2:0];
                    c1_q <= cfg_wdata_i[5:3];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wx0_q         <= 8'd0;
            wy0_q         <= 8'd0;
            ww_q          <= 8'd0;
            wh_q          <= 8'd0;
            wc0_q         <= 3'd0;
            done_sticky_q <= 1'b0;
        end else if (start_fill) begin
            wx0_q         <= x0_q;
            wy0_q         <= y0_q;
            ww_q          <= w_q;
            wh_q          <= h_q;
            wc0_q         <= c0_q;
            done_sticky_q <= 1'b0;
        end else if (state_q == StDone) begin
            done_sticky_q <= 1'b1;
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        case (cfg_addr_i)
            REG_XY:    rdata_d = {16'd0, y0_q, x0_q};
            REG_WH:    rdata_d = {16'd0, h_q, w_q};
            REG_COLOR: rdata_d = {26'd0, c1_q, c0_q};
            REG_CTRL:  rdata_d = {29'd0, pattern_rd, done_sticky_q, state_q == StFill};
            default:   rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata_o = rdata_q;

    // CPU stores always win and pass straight through; the engine only drives idle slots
    always_comb begin
        vmem_we_o    = cpu_vmem_we_i;
        vmem_addr_o  = cpu_vmem_addr_i;
        vmem_wdata_o = cpu_vmem_wdata_i;
        if (!cpu_vmem_we_i && (state_q == StFill)) begin
            vmem_we_o    = walk_inside;
            vmem_addr_o  = walk_addr;
            vmem_wdata_o = pixel_colour;
        end
    end

endmodule

// File: tb/tb_vmem_fill.sv
// Directed self-checking bench for vmem_fill; expected values are hand-computed.
module tb_vmem_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [2:0]  cpu_wdata;
    logic        vmem_we;
    logic [15:0] vmem_addr;
    logic [2:0]  vmem_wdata;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vmem_fill u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_we_i         (cfg_we),
        .cfg_addr_i       (cfg_addr),
        .cfg_wdata_i      (cfg_wdata),
        .cfg_rdata_o      (cfg_rdata),
        .cpu_vmem_we_i    (cpu_we),
        .cpu_vmem_addr_i  (cpu_addr),
        .cpu_vmem_wdata_i (cpu_wdata),
        .vmem_we_o        (vmem_we),
        .vmem_addr_o      (vmem_addr),
        .vmem_wdata_o     (vmem_wdata),
        .busy_o           (busy),
        .done_o           (done)
    );

    // Returns at the negedge after the write edge, i.e. first cycle of a started fill.
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        @(negedge clk);
        @(negedge clk);
        #1;
        d = cfg_rdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 3'd0;
        @(negedge clk); @(negedge clk); #1;
        n_vec++;
        if ({busy, done, vmem_we, cfg_rdata} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b rdata=%h, want all 0",
                     busy, done, vmem_we, cfg_rdata);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_read(2'(i), rd);
            n_vec++;
            if (rd !== 32'd0) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h, want 00000000", i, rd);
            end
        end
        // Idle pass-through of a CPU store
        cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 3'd3; #1;
        n_vec++;
        if ({vmem_we, vmem_addr, vmem_wdata} !== {1'b1, 16'h1234, 3'd3}) begin
            n_err++;
            $display("FAIL idle_passthru: got we=%b addr=%h data=%0d, want 1 1234 3",
                     vmem_we, vmem_addr, vmem_wdata);
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_basic_fill;
        logic [31:0] rd;
        logic [15:0] ea;
        cfg_write(2'd0, 32'h0000_140A);
        cfg_write(2'd1, 32'h0000_0203);
        cfg_write(2'd2, 32'h0000_0005);
        cfg_write(2'd3, 32'h0000_0001);
        for (int i = 0; i < 6; i++) begin
            ea = {8'(20 + i / 3), 8'(10 + i % 3)};
            n_vec++;
            if ({busy, done, vmem_we, vmem_addr, vmem_wdata} !== {3'b101, ea, 3'd5}) begin
                n_err++;
                $display("FAIL basic_px%0d: got busy=%b done=%b we=%b addr=%h data=%0d, want 1 0 1 %h 5",
                         i, busy, done, vmem_we, vmem_addr, vmem_wdata, ea);
            end
            @(negedge clk); #1;
        end
        n_vec++;
        if ({busy, done, vmem_we} !== 3'b010) begin
            n_err++;
            $display("FAIL basic_done: got busy=%b done=%b we=%b, want 0 1 0", busy, done, vmem_we);
        end
        cfg_read(2'd3, rd);
        n_vec++;
        if (rd !== 32'h2) begin
            n_err++;
            $display("FAIL basic_ctrl: got %h, want 00000002", rd);
        end
    endtask

    task automatic test_clip;
        logic ew;
        cfg_write(2'd0, 32'h0000_EFEE);
        cfg_write(2'd1, 32'h0000_0204);
        cfg_write(2'd3, 32'h0000_0001);
        for (int i = 0; i < 8; i++) begin
            ew = (i < 2);
            n_vec++;
            if (busy !== 1'b1 || vmem_we !== ew ||
                (ew && vmem_addr !== {8'd239, 8'(238 + i)})) begin
                n_err++;
                $display("FAIL clip_px%0d: got busy=%b we=%b addr=%h, want 1 %b %h",
                         i, busy, vmem_we, vmem_addr, ew, {8'd239, 8'(238 + i)});
            end
            @(negedge clk); #1;
        end
        n_vec++;
        if ({busy, done} !== 2'b01) begin
            n_err++;
            $display("FAIL clip_done: got busy=%b done=%b, want 0 1", busy, done);
        end
    endtask

    task automatic test_cpu_stall;
        logic [19:0] exp;
        int p;
        cfg_write(2'd0, 32'h0000_0201);
        cfg_write(2'd1, 32'h0000_0108);
        cfg_write(2'd2, 32'h0000_0003);
        cfg_write(2'd3, 32'h0000_0001);
        p = 0;
        for (int k = 0; k < 10; k++) begin
            cpu_we = (k == 2 || k == 3); cpu_addr = 16'h0505; cpu_wdata = 3'd7; #1;
            if (cpu_we) begin
                exp = {1'b1, 16'h0505, 3'd7};
            end else begin
                exp = {1'b1, 8'd2, 8'(1 + p), 3'd3};
                p++;
            end
            n_vec++;
            if ({busy, vmem_we, vmem_addr, vmem_wdata} !== {1'b1, exp}) begin
                n_err++;
                $display("FAIL stall_cyc%0d: got busy=%b we=%b addr=%h data=%0d, want 1 %h",
                         k, busy, vmem_we, vmem_addr, vmem_wdata, exp);
            end
            @(negedge clk);
        end
        cpu_we = 1'b0; #1;
        n_vec++;
        if ({busy, done, vmem_we} !== 3'b010) begin
            n_err++;
            $display("FAIL stall_done: got busy=%b done=%b we=%b, want 0 1 0", busy, done, vmem_we);
        end
    endtask

    task automatic test_empty_and_busy_writes;
        logic [31:0] rd;
        cfg_write(2'd1, 32'h0000_0500);
        cfg_write(2'd3, 32'h0000_0001);
        n_vec++;
        if ({done, busy, vmem_we} !== 3'b100) begin
            n_err++;
            $display("FAIL empty_done: got done=%b busy=%b we=%b, want 1 0 0", done, busy, vmem_we);
        end
        @(negedge clk); #1;
        n_vec++;
        if ({done, busy, vmem_we} !== 3'b000) begin
            n_err++;
            $display("FAIL empty_after: got done=%b busy=%b we=%b, want 0 0 0", done, busy, vmem_we);
        end
        cfg_write(2'd0, 32'h0000_0505);
        cfg_write(2'd1, 32'h0000_0103);
        cfg_write(2'd2, 32'h0000_0002);
        cfg_write(2'd3, 32'h0000_0001);
        for (int k = 0; k < 3; k++) begin
            cfg_we = (k < 2); cfg_addr = (k == 0) ? 2'd2 : 2'd3;
            cfg_wdata = (k == 0) ? 32'h6 : 32'h1;
            #1;
            n_vec++;
            if ({busy, vmem_we, vmem_addr, vmem_wdata} !== {2'b11, 8'd5, 8'(5 + k), 3'd2}) begin
                n_err++;
                $display("FAIL busywr_px%0d: got busy=%b we=%b addr=%h data=%0d, want 1 1 %h 2",
                         k, busy, vmem_we, vmem_addr, vmem_wdata, {8'd5, 8'(5 + k)});
            end
            @(negedge clk);
        end
        cfg_we = 1'b0; #1;
        n_vec++;
        if ({busy, done} !== 2'b01) begin
            n_err++;
            $display("FAIL busywr_done: got busy=%b done=%b, want 0 1", busy, done);
        end
        @(negedge clk); #1;
        n_vec++;
        if ({busy, done, vmem_we} !== 3'b000) begin
            n_err++;
            $display("FAIL busywr_norestart: got busy=%b done=%b we=%b, want 0 0 0",
                     busy, done, vmem_we);
        end
        cfg_read(2'd2, rd);
        n_vec++;
        if (rd !== 32'h2) begin
            n_err++;
            $display("FAIL busywr_color: got %h, want 00000002", rd);
        end
    endtask

    task automatic test_reset_midfill;
        logic [31:0] rd;
        cfg_write(2'd0, 32'h0000_0000);
        cfg_write(2'd1, 32'h0000_0404);
        cfg_write(2'd2, 32'h0000_0004);
        cfg_write(2'd3, 32'h0000_0001);
        repeat (5) @(negedge clk);
        #1;
        n_vec++;
        if ({busy, vmem_we} !== 2'b11) begin
            n_err++;
            $display("FAIL midfill_pre: got busy=%b we=%b, want 1 1", busy, vmem_we);
        end
        rst = 1'b1; #1;
        n_vec++;
        if ({busy, done, vmem_we} !== 3'b000) begin
            n_err++;
            $display("FAIL midfill_rst: got busy=%b done=%b we=%b, want 0 0 0", busy, done, vmem_we);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_vec++;
            if ({busy, done, vmem_we} !== 3'b000) begin
                n_err++;
                $display("FAIL midfill_after%0d: got busy=%b done=%b we=%b, want 0 0 0",
                         i, busy, done, vmem_we);
            end
        end
        cfg_read(2'd3, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL midfill_ctrl: got %h, want 00000000", rd);
        end
    endtask

    task automatic test_pattern;
        logic [31:0] rd;
        logic [2:0]  ec [4];
        logic [31:0] ectrl;
`ifdef VMEM_FILL_PATTERN_EN
        ec[0] = 3'd1; ec[1] = 3'd6; ec[2] = 3'd6; ec[3] = 3'd1; ectrl = 32'h6;
`else
        ec[0] = 3'd1; ec[1] = 3'd1; ec[2] = 3'd1; ec[3] = 3'd1; ectrl = 32'h2;
`endif
        cfg_write(2'd0, 32'h0000_0000);
        cfg_write(2'd1, 32'h0000_0202);
        cfg_write(2'd2, 32'h0000_0031);
        cfg_write(2'd3, 32'h0000_0003);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({vmem_we, vmem_addr, vmem_wdata} !== {1'b1, 8'(i / 2), 8'(i % 2), ec[i]}) begin
                n_err++;
                $display("FAIL pattern_px%0d: got we=%b addr=%h data=%0d, want 1 %h %0d",
                         i, vmem_we, vmem_addr, vmem_wdata, {8'(i / 2), 8'(i % 2)}, ec[i]);
            end
            @(negedge clk); #1;
        end
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL pattern_done: got done=%b, want 1", done);
        end
        cfg_read(2'd3, rd);
        n_vec++;
        if (rd !== ectrl) begin
            n_err++;
            $display("FAIL pattern_ctrl: got %h, want %h", rd, ectrl);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_clip();
        test_cpu_stall();
        test_empty_and_busy_writes();
        test_reset_midfill();
        test_pattern();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
